// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: synchronizes key and tick inputs, debounces the key on tick
// edges, emits press/release pulses, and generates auto-repeat pulses while held.
module key_debounce_repeat #(
    parameter int DEB_DEPTH    = 4,
    parameter int HOLD_TICKS   = 150,
    parameter int REPEAT_TICKS = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_src,
    input  logic key_in,
    output logic key_level,
    output logic key_pulse,
    output logic key_release,
    output logic key_repeat,
    output logic hold_active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] REP_LAST  = 8'(REPEAT_TICKS - 1);

    logic                 key_s1_q, key_s_q;
    logic                 tick_s1_q, tick_s_q;
    logic                 tick_prev_q, tick_armed_q;
    logic                 tick;
    logic [DEB_DEPTH-1:0] hist_q, hist_d;
    logic                 key_level_q, level_d, level_dly_q;
    logic                 key_pulse_q, key_release_q;
    logic                 key_repeat_q, hold_active_q;
    state_t               state_q;
    logic [7:0]           hold_cnt_q;

    // A tick needs tick_s to have been seen low since reset, so a source that is
    // already high when reset drops does not count as an edge.
    assign tick = tick_s_q & ~tick_prev_q & tick_armed_q;

    always_comb begin
        hist_d  = hist_q;
        level_d = key_level_q;
        if (tick) begin
            hist_d = {hist_q[DEB_DEPTH-2:0], key_s_q};
            if (&hist_d) begin
                level_d = 1'b1;
            end else if (~|hist_d) begin
                level_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q      <= 1'b0;
            key_s_q       <= 1'b0;
            tick_s1_q     <= 1'b0;
            tick_s_q      <= 1'b0;
            tick_prev_q   <= 1'b0;
            tick_armed_q  <= 1'b0;
            hist_q        <= '0;
            key_level_q   <= 1'b0;
            level_dly_q   <= 1'b0;
            key_pulse_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_s1_q      <= key_in;
            key_s_q       <= key_s1_q;
            tick_s1_q     <= tick_src;
            tick_s_q      <= tick_s1_q;
            tick_prev_q   <= tick_s_q;
            tick_armed_q  <= tick_armed_q | ~tick_s_q;
            hist_q        <= hist_d;
            key_level_q   <= level_d;
            level_dly_q   <= key_level_q;
            key_pulse_q   <= key_level_q & ~level_dly_q;
            key_release_q <= ~key_level_q & level_dly_q;
        end
    end

    // The FSM looks at the next debounced level so a release on a repeat tick wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_cnt_q    <= 8'd0;
            key_repeat_q  <= 1'b0;
            hold_active_q <= 1'b0;
        end else begin
            key_repeat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (level_d) begin
                        state_q    <= PRESSED;
                        hold_cnt_q <= 8'd0;
                    end
                end
                PRESSED: begin
                    if (!level_d) begin
                        state_q    <= IDLE;
                        hold_cnt_q <= 8'd0;
                    end else if (tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q       <= HOLD;
                            hold_cnt_q    <= 8'd0;
                            key_repeat_q  <= 1'b1;
                            hold_active_q <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (!level_d) begin
                        state_q       <= IDLE;
                        hold_cnt_q    <= 8'd0;
                        hold_active_q <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt_q == REP_LAST) begin
                            hold_cnt_q   <= 8'd0;
                            key_repeat_q <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    hold_cnt_q    <= 8'd0;
                    hold_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_level   = key_level_q;
    assign key_pulse   = key_pulse_q;
    assign key_release = key_release_q;
    assign key_repeat  = key_repeat_q;
    assign hold_active = hold_active_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: random tick and key stimulus compared every cycle
// against a tick-level reference model, plus directed hold/release/reset scenarios.
module tb_key_debounce_repeat;

    localparam int DEB  = 4;
    localparam int HOLD = 150;
    localparam int REP  = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_src = 1'b0;
    logic key_in = 1'b0;
    logic key_level, key_pulse, key_release, key_repeat, hold_active;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int rel_cnt = 0;
    int rep_cnt = 0;
    bit tick_freeze = 1'b0;

    key_debounce_repeat #(
        .DEB_DEPTH   (DEB),
        .HOLD_TICKS  (HOLD),
        .REPEAT_TICKS(REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_src   (tick_src),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_pulse  (key_pulse),
        .key_release(key_release),
        .key_repeat (key_repeat),
        .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: input samples delayed two clocks, tick on a rising sample
    // once a low has been seen, debounce as run lengths, repeat as ticks held.
    bit kp0, kp1, tp0, tp1, tprev, armed;
    int run0, run1;
    bit m_level, m_dly, m_pulse, m_release, m_repeat, m_hold, m_tick;
    int m_held;

    always @(posedge clk) begin
        if (rst) begin
            {kp0, kp1, tp0, tp1, tprev, armed} = '0;
            run0 = 0; run1 = 0;
            {m_level, m_dly, m_pulse, m_release, m_repeat, m_hold, m_tick} = '0;
            m_held = -1;
        end else begin
            m_tick    = tp1 && !tprev && armed;
            m_pulse   = m_level && !m_dly;
            m_release = !m_level && m_dly;
            m_dly     = m_level;
            m_repeat  = 1'b0;
            if (m_tick) begin
                if (kp1) begin run1++; run0 = 0; end
                else begin run0++; run1 = 0; end
                if (run1 >= DEB) m_level = 1'b1;
                if (run0 >= DEB) m_level = 1'b0;
                if (!m_level) begin
                    m_held = -1;
                    m_hold = 1'b0;
                end else if (m_held < 0) begin
                    m_held = 0;
                end else begin
                    m_held++;
                    m_repeat = (m_held >= HOLD) && ((m_held - HOLD) % REP == 0);
                    m_hold   = (m_held >= HOLD);
                end
            end
            armed = armed | !tp1;
            tprev = tp1;
            tp1 = tp0; tp0 = tick_src;
            kp1 = kp0; kp0 = key_in;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("key_level", key_level, m_level);
            check("key_pulse", key_pulse, m_pulse);
            check("key_release", key_release, m_release);
            check("key_repeat", key_repeat, m_repeat);
            check("hold_active", hold_active, m_hold);
            check("pulse_repeat_excl", key_pulse & key_repeat, 0);
            if (key_pulse) pulse_cnt++;
            if (key_release) rel_cnt++;
            if (key_repeat) rep_cnt++;
        end
    end

    // Tick source: square wave with random half-periods of 3..6 clocks.
    initial begin
        int hp;
        hp = 3;
        forever begin
            @(negedge clk);
            if (tick_freeze) tick_src = 1'b1;
            else if (hp == 0) begin
                tick_src = ~tick_src;
                hp = $urandom_range(2, 5);
            end else hp--;
        end
    end

    task automatic clear_counts();
        pulse_cnt = 0; rel_cnt = 0; rep_cnt = 0;
    endtask

    task automatic wait_held(input int target, input int budget);
        int n;
        n = 0;
        while (m_held != target && n < budget) begin
            @(posedge clk); #2; n++;
        end
        if (m_held != target) check("wait_held_timeout", m_held, target);
    endtask

    task automatic wait_level(input bit val, input int budget);
        int n;
        n = 0;
        while (m_level != val && n < budget) begin
            @(posedge clk); #2; n++;
        end
        if (m_level != val) check("wait_level_timeout", m_level, val);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_ticks(input int count);
        int n;
        n = 0;
        repeat (count * 20) begin
            if (n < count) begin
                @(posedge clk); #2;
                if (m_tick) n++;
            end
        end
        if (n < count) check("wait_ticks_timeout", n, count);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, key_level, 0);
        check({tag, "_pulse"}, key_pulse, 0);
        check({tag, "_release"}, key_release, 0);
        check({tag, "_repeat"}, key_repeat, 0);
        check({tag, "_hold"}, hold_active, 0);
    endtask

    initial begin
        logic lvl_before;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Long hold: press pulse once, repeats at HOLD, HOLD+REP, HOLD+2*REP ticks.
        clear_counts();
        key_in = 1'b1;
        wait_held(0, 400);
        wait_held(HOLD + 2 * REP, 5000);
        repeat (2) @(posedge clk);
        #2;
        check("hold_pulse_cnt", pulse_cnt, 1);
        check("hold_repeat_cnt", rep_cnt, 3);
        check("hold_active_on", hold_active, 1);
        @(negedge clk) key_in = 1'b0;
        wait_level(1'b0, 400);
        check("hold_release_cnt", rel_cnt, 1);
        check("hold_active_off", hold_active, 0);

        // Bounce: key flips after every tick for 20 ticks.
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            wait_ticks(1);
            @(negedge clk) key_in = ~key_in;
        end
        key_in = 1'b0;
        wait_ticks(DEB + 1);
        check("bounce_pulse_cnt", pulse_cnt, 0);
        check("bounce_release_cnt", rel_cnt, 0);
        check("bounce_level", key_level, 0);

        // Release debounced exactly on the second repeat tick: release wins.
        clear_counts();
        key_in = 1'b1;
        wait_held(0, 400);
        wait_held(HOLD + REP - DEB, 5000);
        @(negedge clk) key_in = 1'b0;
        wait_level(1'b0, 400);
        check("edge_repeat_cnt", rep_cnt, 1);
        check("edge_release_cnt", rel_cnt, 1);
        check("edge_hold_off", hold_active, 0);

        // Reset pulse during HOLD: outputs clear at once, no release, fresh press.
        key_in = 1'b1;
        wait_held(HOLD + 5, 5000);
        clear_counts();
        @(negedge clk) rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk) rst = 1'b0;
        wait_level(1'b1, 400);
        check("midrst_release_cnt", rel_cnt, 0);
        check("midrst_pulse_cnt", pulse_cnt, 1);
        @(negedge clk) key_in = 1'b0;
        wait_level(1'b0, 400);

        // Frozen tick source: key toggles freely, level must not move.
        @(negedge clk) tick_freeze = 1'b1;
        repeat (10) @(negedge clk);
        lvl_before = key_level;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk) key_in = 1'($urandom_range(0, 1));
        end
        check("frozen_level", key_level, lvl_before);
        @(negedge clk) tick_freeze = 1'b0;
        key_in = 1'b0;
        wait_ticks(DEB + 1);

        // Random key segments of varied length, checked cycle by cycle.
        for (int s = 0; s < 40; s++) begin
            key_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 250)) @(negedge clk);
        end
        key_in = 1'b0;
        wait_ticks(DEB + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
